// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 key matrix scanner.
// Holds the FSM state encoding, matrix geometry and small pure helper functions.
// No logic state lives here; everything is consumed by keypad_scan.
package keypad_scan_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;

  // Row 0 driven low, all other rows released high.
  localparam logic [ROWS-1:0] ROW_INIT = 4'b1110;
  // Column pattern seen when no key on the driven row is pressed.
  localparam logic [COLS-1:0] COL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  // Rotate the single low bit to the next row, wrapping row 3 back to row 0.
  function automatic logic [ROWS-1:0] next_row(input logic [ROWS-1:0] r);
    return {r[ROWS-2:0], r[ROWS-1]};
  endfunction

  // Index of the low bit in a one-hot-low row vector.
  function automatic logic [1:0] row_index(input logic [ROWS-1:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    if (!r[1]) idx = 2'd1;
    if (!r[2]) idx = 2'd2;
    if (!r[3]) idx = 2'd3;
    return idx;
  endfunction

  // Lowest-index low column wins when several keys share the row.
  function automatic logic [1:0] low_col(input logic [COLS-1:0] c);
    logic [1:0] idx;
    if (!c[0])      idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines.
// Latency: 2 clk cycles from d to q. No backpressure; samples every cycle.
// Resets to all ones so an idle (pulled-up) matrix reads as no key.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; only q is ever used by downstream logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low key matrix scanner with press/release debounce.
// Latency: 2 sync cycles + rest of row period + DEBOUNCE_CNT cycles to a key event.
// No backpressure: key_valid is a one-cycle strobe, key_code holds until the next press.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROWS-1:0]   row,
  input  logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_down
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  logic [COLS-1:0] cs;
  state_t          state;
  logic [SW-1:0]   scan_cnt;
  logic [DW-1:0]   db_cnt;
  logic [COLS-1:0] pat;
  logic [1:0]      row_idx;

  keypad_sync #(.W(COLS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col),
    .q   (cs)
  );

  // Scan / debounce FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      row       <= ROW_INIT;
      scan_cnt  <= '0;
      db_cnt    <= '0;
      pat       <= COL_IDLE;
      row_idx   <= 2'd0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (cs == COL_IDLE) begin
              row <= next_row(row);
            end else begin
              // Something is down on this row: freeze here and qualify it.
              row_idx <= row_index(row);
              pat     <= cs;
              db_cnt  <= '0;
              state   <= PRESS_DB;
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end

        PRESS_DB: begin
          if (cs == pat) begin
            if (db_cnt == DB_LAST) begin
              key_valid <= 1'b1;
              key_down  <= 1'b1;
              key_code  <= {row_idx, low_col(pat)};
              state     <= HELD;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            // Bounce or pattern change: give up and move on to the next row.
            row      <= next_row(row);
            scan_cnt <= '0;
            state    <= SCAN;
          end
        end

        HELD: begin
          // Pattern changes while held are deliberately ignored.
          if (cs == COL_IDLE) begin
            db_cnt <= '0;
            state  <= REL_DB;
          end
        end

        REL_DB: begin
          if (cs == COL_IDLE) begin
            if (db_cnt == DB_LAST) begin
              key_down <= 1'b0;
              row      <= next_row(row);
              scan_cnt <= '0;
              state    <= SCAN;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            state <= HELD;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized and directed bench for keypad_scan against a behavioural matrix model.
// Drives a virtual 4x4 key matrix (or a forced column pattern) from the DUT's row output.
// Compares row, key_valid, key_down and key_code every cycle.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col = 4'hF;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  int total = 0;
  int bad   = 0;
  int ev_cnt = 0;

  // Virtual matrix: keys[r*4+c] pressed. Override forces raw col.
  logic [15:0] keys = '0;
  logic        ov_en = 1'b0;
  logic [3:0]  ov_val = 4'hF;

  // Reference model state.
  int         m_mode;   // 0 scanning, 1 confirming press, 2 holding, 3 confirming release
  int         m_row, m_tick, m_run, m_lrow;
  logic [3:0] m_pat, m_s1, m_s2, m_code;
  bit         m_valid, m_down;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] env_col();
    logic [3:0] c;
    c = 4'hF;
    if (ov_en) return ov_val;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (keys[r*4+k] && !row[r]) c[k] = 1'b0;
    return c;
  endfunction

  function automatic int first_low(input logic [3:0] p);
    for (int i = 0; i < 4; i++)
      if (!p[i]) return i;
    return 3;
  endfunction

  function automatic logic [3:0] exp_row();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << m_row);
  endfunction

  // One clock of the behavioural model, using the col/rst seen at this edge.
  task automatic model_step();
    logic [3:0] cs;
    cs = m_s2;
    m_valid = 0;
    if (rst) begin
      m_mode = 0; m_row = 0; m_tick = 0; m_run = 0; m_lrow = 0;
      m_pat = 4'hF; m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0; m_down = 0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = col;
    case (m_mode)
      0: begin
        if (m_tick == SD - 1) begin
          m_tick = 0;
          if (cs == 4'hF) m_row = (m_row + 1) % 4;
          else begin m_mode = 1; m_lrow = m_row; m_pat = cs; m_run = 0; end
        end else m_tick++;
      end
      1: begin
        if (cs == m_pat) begin
          m_run++;
          if (m_run == DB) begin
            m_mode = 2; m_valid = 1; m_down = 1;
            m_code = 4'(m_lrow * 4 + first_low(m_pat));
          end
        end else begin
          m_mode = 0; m_row = (m_row + 1) % 4; m_tick = 0;
        end
      end
      2: begin
        if (cs == 4'hF) begin m_mode = 3; m_run = 0; end
      end
      default: begin
        if (cs == 4'hF) begin
          m_run++;
          if (m_run == DB) begin
            m_down = 0; m_mode = 0; m_row = (m_row + 1) % 4; m_tick = 0;
          end
        end else m_mode = 2;
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    col = env_col();
    @(posedge clk);
    model_step();
    #1;
    if (key_valid === 1'b1) ev_cnt++;
    chk("row", row, exp_row());
    chk("key_valid", key_valid, m_valid);
    chk("key_down", key_down, m_down);
    chk("key_code", key_code, m_code);
  endtask

  task automatic wait_event(input string tag, input int limit);
    int e0;
    int n;
    e0 = ev_cnt;
    n = 0;
    while (ev_cnt == e0 && n < limit) begin step(); n++; end
    chk(tag, ev_cnt - e0, 1);
  endtask

  task automatic wait_release(input string tag, input int limit);
    int n;
    n = 0;
    while (key_down === 1'b1 && n < limit) begin step(); n++; end
    chk(tag, key_down, 0);
  endtask

  initial begin
    int e0;
    int n;

    // Reset and idle scan.
    rst = 1'b1;
    step(); step();
    chk("rst_row", row, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_down", key_down, 0);
    rst = 1'b0;
    e0 = ev_cnt;
    repeat (40) step();
    chk("idle_no_event", ev_cnt - e0, 0);

    // Press row 2 col 1, hold, no repeat.
    keys = 16'h0200;
    e0 = ev_cnt;
    wait_event("press_r2c1_seen", 200);
    chk("press_r2c1_code", key_code, 4'h9);
    chk("press_r2c1_row", row, 4'b1011);
    chk("press_r2c1_down", key_down, 1);
    repeat (30) step();
    chk("held_no_repeat", ev_cnt - e0, 1);

    // Release; scan resumes at the next row.
    keys = '0;
    wait_release("release_r2c1", 100);
    chk("release_row_next", row, 4'b0111);
    chk("release_no_event", ev_cnt - e0, 1);

    // Short press glitch never becomes an event.
    e0 = ev_cnt;
    ov_en = 1'b1; ov_val = 4'b1110;
    n = 0;
    while (m_mode != 1 && n < 50) begin step(); n++; end
    chk("glitch_entered", m_mode, 1);
    repeat (3) step();
    ov_val = 4'hF;
    repeat (30) step();
    ov_en = 1'b0;
    chk("glitch_no_event", ev_cnt - e0, 0);

    // Release bounce keeps key_down high.
    keys = 16'h0080;
    e0 = ev_cnt;
    wait_event("bounce_press_seen", 200);
    chk("bounce_press_code", key_code, 4'h7);
    keys = '0;
    ov_en = 1'b1;
    ov_val = 4'hF;    repeat (5) step();
    ov_val = 4'b0111; step();
    ov_val = 4'hF;    repeat (5) step();
    chk("bounce_still_down", key_down, 1);
    wait_release("bounce_release", 40);
    chk("bounce_single_event", ev_cnt - e0, 1);
    ov_en = 1'b0;

    // Two columns on row 3: lowest column wins.
    keys = 16'h5000;
    wait_event("dual_press_seen", 200);
    chk("dual_code", key_code, 4'hC);

    // Reset while held.
    rst = 1'b1;
    step();
    rst = 1'b0;
    keys = '0;
    chk("rst_held_row", row, 4'b1110);
    chk("rst_held_down", key_down, 0);
    chk("rst_held_code", key_code, 4'h0);
    repeat (20) step();

    // Randomized presses, holds, glitches and releases.
    for (int it = 0; it < 30; it++) begin
      int r;
      int k;
      r = $urandom_range(0, 3);
      k = $urandom_range(0, 3);
      keys = '0;
      keys[r*4+k] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[r*4 + $urandom_range(0, 3)] = 1'b1;
      repeat ($urandom_range(0, 60)) begin
        if ($urandom_range(0, 9) == 0) begin
          ov_en = 1'b1;
          ov_val = 4'($urandom_range(0, 15));
        end else begin
          ov_en = 1'b0;
        end
        step();
      end
      ov_en = 1'b0;
      keys = '0;
      repeat ($urandom_range(5, 40)) step();
    end
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
